// File: rtl/instr_queue.sv
// instr_queue: in-order instruction/PC queue between fetch and decode.
//
// Parameters
//   DEPTH   entry count (power of two, >= 2)
//   IWIDTH  instruction width
//   PCW     PC width
//   BYPASS  1 = an empty queue passes the push straight to the pop side
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   flush        discard all contents (priority over push/pop)
//   push_valid   fetch offers push_instr/push_pc
//   push_ready   queue can take the push (not full, not flushing)
//   push_instr   instruction bits
//   push_pc      instruction PC
//   pop_valid    head entry available
//   pop_ready    decode consumes the head
//   pop_instr    head instruction (don't-care while pop_valid=0)
//   pop_pc       head PC (don't-care while pop_valid=0)
//   occupancy    number of stored entries
//   stall_cnt    saturating count of cycles a push was back-pressured
module instr_queue #(
  parameter int DEPTH  = 4,
  parameter int IWIDTH = 32,
  parameter int PCW    = 32,
  parameter int BYPASS = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [IWIDTH-1:0]        push_instr,
  input  logic [PCW-1:0]           push_pc,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [IWIDTH-1:0]        pop_instr,
  output logic [PCW-1:0]           pop_pc,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0]       occ_q;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [IWIDTH-1:0] mem_instr [DEPTH];
  logic [PCW-1:0]    mem_pc    [DEPTH];

  logic bypass_en;
  logic pass_thru;
  logic wr_en;
  logic rd_en;

  // Bypass is only offered when nothing is stored, so ordering is preserved.
  // It is gated by reset so pop_valid stays low while reset is asserted.
  assign bypass_en = (BYPASS != 0) && (occ_q == '0) && !flush && reset;
  assign pass_thru = bypass_en && push_valid && pop_ready;

  // push_ready depends only on state and flush; no path from pop_ready.
  assign push_ready = (occ_q < FULL_CNT) && !flush;
  assign pop_valid  = bypass_en ? push_valid : ((occ_q != '0) && !flush);
  assign pop_instr  = bypass_en ? push_instr : mem_instr[rd_ptr];
  assign pop_pc     = bypass_en ? push_pc    : mem_pc[rd_ptr];
  assign occupancy  = occ_q;

  // A passed-through instruction is neither written nor popped from storage.
  assign wr_en = push_valid && push_ready && !pass_thru;
  assign rd_en = pop_valid && pop_ready && !bypass_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      occ_q  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   occ_q <= occ_q + (AW+1)'(1);
        2'b01:   occ_q <= occ_q - (AW+1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (push_valid && !push_ready && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_instr[wr_ptr] <= push_instr;
      mem_pc[wr_ptr]    <= push_pc;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        rst_n;

  // DUT 0: DEPTH=4, BYPASS=0
  logic        flush, pv, pr;
  logic [31:0] pi, ppc;
  logic        push_ready, pop_valid;
  logic [31:0] pop_instr, pop_pc;
  logic [2:0]  occ;
  logic [31:0] stall;

  // DUT 1: DEPTH=4, BYPASS=1
  logic        b_flush, b_pv, b_pr;
  logic [31:0] b_pi, b_ppc;
  logic        b_push_ready, b_pop_valid;
  logic [31:0] b_pop_instr, b_pop_pc;
  logic [2:0]  b_occ;
  logic [31:0] b_stall;

  int tests = 0;
  int fails = 0;
  int n_pops = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  instr_queue #(.DEPTH(4), .IWIDTH(32), .PCW(32), .BYPASS(0)) dut0 (
    .clk(clk), .reset(rst_n), .flush(flush),
    .push_valid(pv), .push_ready(push_ready), .push_instr(pi), .push_pc(ppc),
    .pop_valid(pop_valid), .pop_ready(pr), .pop_instr(pop_instr), .pop_pc(pop_pc),
    .occupancy(occ), .stall_cnt(stall)
  );

  instr_queue #(.DEPTH(4), .IWIDTH(32), .PCW(32), .BYPASS(1)) dut1 (
    .clk(clk), .reset(rst_n), .flush(b_flush),
    .push_valid(b_pv), .push_ready(b_push_ready), .push_instr(b_pi), .push_pc(b_ppc),
    .pop_valid(b_pop_valid), .pop_ready(b_pr), .pop_instr(b_pop_instr), .pop_pc(b_pop_pc),
    .occupancy(b_occ), .stall_cnt(b_stall)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a push to DUT 0 that is known to be accepted and record it.
  task automatic do_push(input logic [31:0] instr);
    pv  = 1'b1;
    pi  = instr;
    ppc = 32'h1000 + (instr << 2);
    exp_q.push_back({ppc, pi});
    step();
  endtask

  // Scoreboard monitor for DUT 0: every completed pop must match the queue head.
  always @(negedge clk) begin
    if (rst_n && pop_valid && pr) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_unexpected: got instr %0h with no entry expected", pop_instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("pop_instr", {32'h0, pop_instr}, {32'h0, e[31:0]});
        check("pop_pc", {32'h0, pop_pc}, {32'h0, e[63:32]});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; pv = 1'b0; pr = 1'b0; pi = '0; ppc = '0;
    b_flush = 1'b0; b_pv = 1'b1; b_pr = 1'b1; b_pi = 32'hAB; b_ppc = 32'h2AC;
    #3;
    check("rst_occ", {61'h0, occ}, 64'd0);
    check("rst_push_ready", {63'h0, push_ready}, 64'd1);
    check("rst_pop_valid", {63'h0, pop_valid}, 64'd0);
    check("rst_stall", {32'h0, stall}, 64'd0);
    check("rst_bypass_suppressed", {63'h0, b_pop_valid}, 64'd0);
    b_pv = 1'b0;
    #5 rst_n = 1'b1;
    step();

    // No push-to-pop path without bypass
    pv = 1'b1; pi = 32'h11; #1;
    check("nobypass_pop_valid", {63'h0, pop_valid}, 64'd0);

    // Fill and drain
    pr = 1'b0;
    do_push(32'h11); do_push(32'h22); do_push(32'h33); do_push(32'h44);
    pv = 1'b0; #1;
    check("full_occ", {61'h0, occ}, 64'd4);
    check("full_push_ready", {63'h0, push_ready}, 64'd0);
    pv = 1'b1; pi = 32'h55; ppc = 32'h55;
    step(); step(); step();
    check("stall_3", {32'h0, stall}, 64'd3);
    pv = 1'b0; pr = 1'b1;
    step(); step(); step(); step();
    check("drained_pop_valid", {63'h0, pop_valid}, 64'd0);
    check("drained_occ", {61'h0, occ}, 64'd0);

    // Simultaneous push and pop
    pr = 1'b0;
    do_push(32'hA1); do_push(32'hA2);
    pr = 1'b1;
    do_push(32'hA3);
    check("simul_occ2", {61'h0, occ}, 64'd2);
    pr = 1'b0;
    do_push(32'hA4); do_push(32'hA5);
    check("simul_occ4", {61'h0, occ}, 64'd4);
    pv = 1'b1; pi = 32'hA6; ppc = 32'hA6; pr = 1'b1;
    step();
    check("full_simul_occ3", {61'h0, occ}, 64'd3);
    pv = 1'b0;
    step(); step(); step();
    check("simul_drained", {61'h0, occ}, 64'd0);

    // Wrap-around stream 0..9
    pr = 1'b1;
    for (int i = 0; i < 10; i++) do_push(i);
    pv = 1'b0;
    step();
    check("wrap_occ", {61'h0, occ}, 64'd0);
    check("wrap_stall", {32'h0, stall}, 64'd4);

    // Flush at occupancy 3 with a push present
    pr = 1'b0;
    do_push(32'hB1); do_push(32'hB2); do_push(32'hB3);
    pv = 1'b1; pi = 32'hB4; ppc = 32'hB4; flush = 1'b1; #1;
    check("flush_push_ready", {63'h0, push_ready}, 64'd0);
    check("flush_pop_valid", {63'h0, pop_valid}, 64'd0);
    step();
    flush = 1'b0; pv = 1'b0; #1;
    exp_q.delete();
    check("flush_occ", {61'h0, occ}, 64'd0);
    check("flush_pop_valid_after", {63'h0, pop_valid}, 64'd0);
    check("flush_stall", {32'h0, stall}, 64'd4);
    do_push(32'hC1);
    pv = 1'b0; pr = 1'b1;
    step();
    pr = 1'b0;

    // Async reset at occupancy 2, stall_cnt 5
    do_push(32'hD1); do_push(32'hD2); do_push(32'hD3); do_push(32'hD4);
    pv = 1'b1; pi = 32'hD5; ppc = 32'hD5;
    step();
    pv = 1'b0; pr = 1'b1;
    step(); step();
    pr = 1'b0; #1;
    check("pre_reset_occ", {61'h0, occ}, 64'd2);
    check("pre_reset_stall", {32'h0, stall}, 64'd5);
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("async_occ", {61'h0, occ}, 64'd0);
    check("async_stall", {32'h0, stall}, 64'd0);
    check("async_push_ready", {63'h0, push_ready}, 64'd1);
    check("async_pop_valid", {63'h0, pop_valid}, 64'd0);
    #2;
    rst_n = 1'b1;
    pv = 1'b1; pi = 32'hE1; ppc = 32'h1000 + (32'hE1 << 2);
    exp_q.push_back({ppc, pi});
    step();
    check("first_push_after_reset", {61'h0, occ}, 64'd1);
    pv = 1'b0; pr = 1'b1;
    step();
    pr = 1'b0;

    // Bypass DUT: pass-through then store
    b_pv = 1'b1; b_pi = 32'hAB; b_ppc = 32'h2AC; b_pr = 1'b1; #1;
    check("byp_pop_valid", {63'h0, b_pop_valid}, 64'd1);
    check("byp_pop_instr", {32'h0, b_pop_instr}, 64'hAB);
    check("byp_pop_pc", {32'h0, b_pop_pc}, 64'h2AC);
    step();
    check("byp_occ0", {61'h0, b_occ}, 64'd0);
    b_pr = 1'b0;
    step();
    b_pv = 1'b0; #1;
    check("byp_occ1", {61'h0, b_occ}, 64'd1);
    check("byp_stored_valid", {63'h0, b_pop_valid}, 64'd1);
    check("byp_stored_instr", {32'h0, b_pop_instr}, 64'hAB);
    b_pr = 1'b1;
    step();
    check("byp_drained", {61'h0, b_occ}, 64'd0);

    step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("pop_count", 64'(n_pops), 64'd23);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
